// File: rtl/axil_reg_responder.sv
// rtl/axil_reg_responder.sv - AXI4-Lite responder for a four-register window
//
// Registers at BASE_ADDR: 0x0 CTRL0 (RW), 0x4 CTRL1 (RW),
// 0x8 SUM (RO, CTRL0+CTRL1), 0xC WCNT (RO, completed write count).
// Optional feature macro: AXIL_REG_RESPONDER_SLVERR_EN (SLVERR on
// out-of-range accesses and on writes to SUM/WCNT).
//
// Ports:
//   s0_axi_aclk, s0_axi_areset     clock, synchronous active-high reset
//   s0_axi_aw*                     write address channel
//   s0_axi_w*                      write data channel
//   s0_axi_b*                      write response channel
//   s0_axi_ar*                     read address channel
//   s0_axi_r*                      read data channel
module axil_reg_responder #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    RESP_WIDTH = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    s0_axi_aclk,
  input  logic                    s0_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic [RESP_WIDTH-1:0]   s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s0_axi_rresp,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

`ifdef AXIL_REG_RESPONDER_SLVERR_EN
  localparam logic SLVERR_EN = 1'b1;
`else
  localparam logic SLVERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  // Register file
  logic [DATA_WIDTH-1:0] ctrl0_q, ctrl0_d;
  logic [DATA_WIDTH-1:0] ctrl1_q, ctrl1_d;
  logic [DATA_WIDTH-1:0] wcnt_q, wcnt_d;

  // Write channel state
  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:2] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [RESP_WIDTH-1:0] bresp_q, bresp_d;

  // Read channel state
  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [RESP_WIDTH-1:0] rresp_q, rresp_d;

  // Commit bundle: whichever handshake completes the pair supplies its
  // half straight from the bus, the other half comes from the latch.
  logic                  commit;
  logic [ADDR_WIDTH-1:2] c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic [STRB_WIDTH-1:0] c_strb;
  logic                  c_in_range;
  logic                  c_err;

  logic aw_hs, w_hs, ar_hs;
  logic r_in_range;
  logic [DATA_WIDTH-1:0] r_value;

  // Byte-offset bits do not take part in decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s0_axi_awaddr[1:0], s0_axi_araddr[1:0]};

  assign aw_hs = s0_axi_awvalid && awready_q;
  assign w_hs  = s0_axi_wvalid  && wready_q;
  assign ar_hs = s0_axi_arvalid && arready_q;

  assign c_in_range = (c_addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
  // SUM and WCNT (index bit 1 set) are read-only.
  assign c_err      = !c_in_range || c_addr[3];

  // Write FSM
  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;
    c_addr    = waddr_q;
    c_data    = wdata_q;
    c_strb    = wstrb_q;

    case (w_state_q)
      W_IDLE: begin
        // Readies come up here on the first cycle out of reset.
        awready_d = 1'b1;
        wready_d  = 1'b1;
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          c_addr = s0_axi_awaddr[ADDR_WIDTH-1:2];
          c_data = s0_axi_wdata;
          c_strb = s0_axi_wstrb;
        end else if (aw_hs) begin
          waddr_d   = s0_axi_awaddr[ADDR_WIDTH-1:2];
          awready_d = 1'b0;
          w_state_d = W_HAVE_ADDR;
        end else if (w_hs) begin
          wdata_d   = s0_axi_wdata;
          wstrb_d   = s0_axi_wstrb;
          wready_d  = 1'b0;
          w_state_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        if (w_hs) begin
          commit = 1'b1;
          c_data = s0_axi_wdata;
          c_strb = s0_axi_wstrb;
        end
      end
      W_HAVE_DATA: begin
        if (aw_hs) begin
          commit = 1'b1;
          c_addr = s0_axi_awaddr[ADDR_WIDTH-1:2];
        end
      end
      W_RESP: begin
        if (s0_axi_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    if (commit) begin
      awready_d = 1'b0;
      wready_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = (SLVERR_EN && c_err) ? RESP_SLVERR : RESP_OKAY;
      w_state_d = W_RESP;
    end
  end

  // Register file update; WCNT counts errored writes too.
  always_comb begin
    ctrl0_d = ctrl0_q;
    ctrl1_d = ctrl1_q;
    wcnt_d  = wcnt_q;
    if (commit) begin
      wcnt_d = wcnt_q + DATA_WIDTH'(1);
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (c_in_range && c_strb[i]) begin
          if (c_addr[3:2] == 2'd0) ctrl0_d[8*i +: 8] = c_data[8*i +: 8];
          if (c_addr[3:2] == 2'd1) ctrl1_d[8*i +: 8] = c_data[8*i +: 8];
        end
      end
    end
  end

  // Read decode uses the current register values, so a read sharing an
  // edge with a write commit sees the pre-write contents.
  assign r_in_range = (s0_axi_araddr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);

  always_comb begin
    r_value = '0;
    if (r_in_range) begin
      case (s0_axi_araddr[3:2])
        2'd0:    r_value = ctrl0_q;
        2'd1:    r_value = ctrl1_q;
        2'd2:    r_value = ctrl0_q + ctrl1_q;
        default: r_value = wcnt_q;
      endcase
    end
  end

  // Read FSM
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rdata_d   = r_value;
          rresp_d   = (SLVERR_EN && !r_in_range) ? RESP_SLVERR : RESP_OKAY;
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s0_axi_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s0_axi_aclk) begin
    if (s0_axi_areset) begin
      ctrl0_q   <= '0;
      ctrl1_q   <= '0;
      wcnt_q    <= '0;
      w_state_q <= W_IDLE;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      ctrl0_q   <= ctrl0_d;
      ctrl1_q   <= ctrl1_d;
      wcnt_q    <= wcnt_d;
      w_state_q <= w_state_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s0_axi_awready = awready_q;
  assign s0_axi_wready  = wready_q;
  assign s0_axi_bvalid  = bvalid_q;
  assign s0_axi_bresp   = bresp_q;
  assign s0_axi_arready = arready_q;
  assign s0_axi_rvalid  = rvalid_q;
  assign s0_axi_rdata   = rdata_q;
  assign s0_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axil_reg_responder.sv
// tb/tb_axil_reg_responder.sv - scoreboard bench for axil_reg_responder
module tb_axil_reg_responder;

  localparam logic [2:0] OK = 3'd0;
`ifdef AXIL_REG_RESPONDER_SLVERR_EN
  localparam logic [2:0] SLV = 3'd2;
`else
  localparam logic [2:0] SLV = 3'd0;
`endif

  logic        clk = 1'b0;
  logic        areset;
  logic [7:0]  awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [2:0]  bresp;
  logic        bvalid, bready;
  logic [7:0]  araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [2:0]  rresp;
  logic        rvalid, rready;

  always #5 clk = ~clk;

  axil_reg_responder dut (
    .s0_axi_aclk    (clk),
    .s0_axi_areset  (areset),
    .s0_axi_awaddr  (awaddr),
    .s0_axi_awvalid (awvalid),
    .s0_axi_awready (awready),
    .s0_axi_wdata   (wdata),
    .s0_axi_wstrb   (wstrb),
    .s0_axi_wvalid  (wvalid),
    .s0_axi_wready  (wready),
    .s0_axi_bresp   (bresp),
    .s0_axi_bvalid  (bvalid),
    .s0_axi_bready  (bready),
    .s0_axi_araddr  (araddr),
    .s0_axi_arvalid (arvalid),
    .s0_axi_arready (arready),
    .s0_axi_rdata   (rdata),
    .s0_axi_rresp   (rresp),
    .s0_axi_rvalid  (rvalid),
    .s0_axi_rready  (rready)
  );

  typedef struct packed {
    logic [2:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t bq[$];
  exp_t rq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a response is consumed on the edge following a negedge where
  // valid and ready are both high.
  always @(negedge clk) begin
    exp_t e;
    if (!areset) begin
      if (bvalid && bready) begin
        if (bq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL b_unexpected: got bvalid=1 expected no response at %0t", $time);
        end else begin
          e = bq.pop_front();
          check("bresp", {29'd0, bresp}, {29'd0, e.resp});
        end
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL r_unexpected: got rvalid=1 expected no response at %0t", $time);
        end else begin
          e = rq.pop_front();
          check("rresp", {29'd0, rresp}, {29'd0, e.resp});
          check("rdata", rdata, e.data);
        end
      end
    end
  end

  task automatic wait_b_hs();
    int n = 0;
    logic hs = 1'b0;
    do begin
      @(negedge clk);
      hs = bvalid && bready;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < 50);
    check("b_handshake", {31'd0, hs}, 32'd1);
  endtask

  // AW and W presented together.
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [2:0] er);
    int n = 0;
    logic aw_acc = 1'b0, w_acc = 1'b0;
    bq.push_back(exp_t'({er, 32'd0}));
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    do begin
      @(negedge clk);
      if (awvalid && awready) aw_acc = 1'b1;
      if (wvalid && wready) w_acc = 1'b1;
      @(posedge clk); #1;
      if (aw_acc) awvalid = 1'b0;
      if (w_acc) wvalid = 1'b0;
      n++;
    end while (!(aw_acc && w_acc) && n < 20);
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_accept", {30'd0, aw_acc, w_acc}, 32'd3);
    check("b_latency", {31'd0, bvalid}, 32'd1);
    wait_b_hs();
  endtask

  // W first, AW after gap cycles; checks the channel readies while waiting.
  task automatic wr_wfirst(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [2:0] er, input int gap);
    int n = 0;
    logic acc = 1'b0;
    bq.push_back(exp_t'({er, 32'd0}));
    wdata = d; wstrb = s; wvalid = 1'b1;
    do begin
      @(negedge clk);
      acc = wready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 20);
    wvalid = 1'b0;
    check("w_accept", {31'd0, acc}, 32'd1);
    repeat (gap) begin
      @(negedge clk);
      check("wait_awready", {31'd0, awready}, 32'd1);
      check("wait_wready", {31'd0, wready}, 32'd0);
    end
    @(posedge clk); #1;
    awaddr = a; awvalid = 1'b1;
    n = 0; acc = 1'b0;
    do begin
      @(negedge clk);
      acc = awready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 20);
    awvalid = 1'b0;
    check("aw_accept", {31'd0, acc}, 32'd1);
    check("b_latency", {31'd0, bvalid}, 32'd1);
    wait_b_hs();
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] ed, input logic [2:0] er);
    int n = 0;
    logic acc = 1'b0, hs = 1'b0;
    rq.push_back(exp_t'({er, ed}));
    araddr = a; arvalid = 1'b1;
    do begin
      @(negedge clk);
      acc = arready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 20);
    arvalid = 1'b0;
    check("ar_accept", {31'd0, acc}, 32'd1);
    check("r_latency", {31'd0, rvalid}, 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      hs = rvalid && rready;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < 50);
    check("r_handshake", {31'd0, hs}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    awaddr = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1;
    araddr = '0; arvalid = 1'b0;
    rready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready", {31'd0, wready}, 32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_bresp", {29'd0, bresp}, 32'd0);
    check("rst_rresp", {29'd0, rresp}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    areset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_awready", {31'd0, awready}, 32'd1);
    check("post_rst_wready", {31'd0, wready}, 32'd1);
    check("post_rst_arready", {31'd0, arready}, 32'd1);

    // Simultaneous AW+W, read back, write count
    wr(8'h00, 32'hDEADBEEF, 4'hF, OK);
    rd(8'h00, 32'hDEADBEEF, OK);
    rd(8'h0C, 32'd1, OK);

    // W leads AW by 3 cycles, partial strobe
    wr_wfirst(8'h04, 32'h11223344, 4'h5, OK, 3);
    rd(8'h04, 32'h00220044, OK);

    // SUM wraps; low address bits ignored
    wr(8'h00, 32'hFFFFFFFF, 4'hF, OK);
    wr(8'h04, 32'h00000002, 4'hF, OK);
    rd(8'h08, 32'h00000001, OK);
    rd(8'h07, 32'h00000002, OK);

    // Write to SUM and out-of-range read
    wr(8'h08, 32'h12345678, 4'hF, SLV);
    rd(8'h40, 32'h00000000, SLV);
    rd(8'h00, 32'hFFFFFFFF, OK);
    rd(8'h04, 32'h00000002, OK);
    rd(8'h0C, 32'd5, OK);

    // Back-pressure on B
    bready = 1'b0;
    fork
      wr(8'h00, 32'h0000AAAA, 4'hF, OK);
      begin
        @(posedge clk); #1;
        repeat (5) begin
          @(negedge clk);
          check("stall_bvalid", {31'd0, bvalid}, 32'd1);
          check("stall_bresp", {29'd0, bresp}, {29'd0, OK});
          check("stall_awready", {31'd0, awready}, 32'd0);
        end
        @(posedge clk); #1;
        bready = 1'b1;
      end
    join

    // Back-pressure on R
    rready = 1'b0;
    fork
      rd(8'h00, 32'h0000AAAA, OK);
      begin
        @(posedge clk); #1;
        repeat (5) begin
          @(negedge clk);
          check("stall_rvalid", {31'd0, rvalid}, 32'd1);
          check("stall_rdata", rdata, 32'h0000AAAA);
          check("stall_arready", {31'd0, arready}, 32'd0);
        end
        @(posedge clk); #1;
        rready = 1'b1;
      end
    join

    // Read sharing an edge with a write commit sees the old contents
    fork
      wr(8'h00, 32'h55555555, 4'hF, OK);
      rd(8'h00, 32'h0000AAAA, OK);
    join
    fork
      wr(8'h04, 32'h00000001, 4'hF, OK);
      rd(8'h0C, 32'd7, OK);
    join
    rd(8'h00, 32'h55555555, OK);
    rd(8'h0C, 32'd8, OK);
    rd(8'h08, 32'h55555556, OK);

    // Reset while holding an address
    awaddr = 8'h00; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("have_addr_awready", {31'd0, awready}, 32'd0);
    check("have_addr_wready", {31'd0, wready}, 32'd1);
    areset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("mid_rst_awready", {31'd0, awready}, 32'd0);
    areset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("after_rst_bvalid", {31'd0, bvalid}, 32'd0);
    end
    rd(8'h00, 32'd0, OK);
    rd(8'h04, 32'd0, OK);
    rd(8'h0C, 32'd0, OK);
    wr_wfirst(8'h04, 32'h00000099, 4'hF, OK, 1);
    rd(8'h00, 32'd0, OK);
    rd(8'h04, 32'h00000099, OK);
    rd(8'h0C, 32'd1, OK);

    for (int i = 0; i < 20 && (bq.size() != 0 || rq.size() != 0); i++) @(posedge clk);
    check("queues_drained", bq.size() + rq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
